// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner with frame-level debounce and optional BCD entry.
// Columns are driven active-low one at a time; rows are sampled once per column slot.
// Optional feature macro: KEYPAD_BCD_ENTRY_EN (shifts accepted digit keys into four BCD digits).
module keypad_scan #(
    parameter int unsigned SCAN_TICKS     = 100_000,
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input  logic       clk_100MHz,
    input  logic       reset_n,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held,
    output logic [3:0] ones,
    output logic [3:0] tens,
    output logic [3:0] hundreds,
    output logic [3:0] thousands
);

    localparam int unsigned TW = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
    localparam int unsigned CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [TW-1:0] TERM    = TW'(SCAN_TICKS - 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_SCANS);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} state_t;

    logic [3:0]    row_meta, row_sync;
    logic [TW-1:0] timer;
    logic [1:0]    col_sel, col_sel_nxt;
    logic          slot_end, frame_close;
    logic          row_hit;
    logic [1:0]    row_idx;
    logic          det_valid;
    logic [3:0]    det_code;
    logic          cand_valid;
    logic [3:0]    cand_code;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt, cnt_inc;
    logic [3:0]    lat, lat_nxt;
    logic [3:0]    key_code_nxt;
    logic          key_valid_nxt, key_held_nxt;
    logic          accept_c;

    // Two-flop synchronizer for the asynchronous row lines
    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            row_meta <= '0;
            row_sync <= '0;
        end else begin
            row_meta <= row;
            row_sync <= row_meta;
        end
    end

    assign slot_end    = (timer == TERM);
    assign col_sel_nxt = col_sel + 2'd1;
    assign frame_close = slot_end && (col_sel == 2'd3);

    // Slot timer, column select and registered column drive
    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            timer   <= '0;
            col_sel <= 2'd0;
            col     <= 4'b1110;
        end else if (slot_end) begin
            timer   <= '0;
            col_sel <= col_sel_nxt;
            col     <= ~(4'b0001 << col_sel_nxt);
        end else begin
            timer   <= timer + TW'(1);
        end
    end

    // Lowest active-low row in the current column
    always_comb begin
        row_hit = (row_sync != 4'hF);
        row_idx = 2'd0;
        if      (!row_sync[0]) row_idx = 2'd0;
        else if (!row_sync[1]) row_idx = 2'd1;
        else if (!row_sync[2]) row_idx = 2'd2;
        else if (!row_sync[3]) row_idx = 2'd3;
    end

    // Earlier columns take priority, so the first hit of the frame is kept
    assign cand_valid = det_valid | row_hit;
    assign cand_code  = det_valid ? det_code : {row_idx, col_sel};

    // Frame detector: remembers first hit, cleared at frame close
    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            det_valid <= 1'b0;
            det_code  <= 4'h0;
        end else if (frame_close) begin
            det_valid <= 1'b0;
            det_code  <= 4'h0;
        end else if (slot_end && !det_valid && row_hit) begin
            det_valid <= 1'b1;
            det_code  <= {row_idx, col_sel};
        end
    end

    assign cnt_inc = (cnt >= CNT_MAX) ? cnt : cnt + CW'(1);

    // Debounce FSM next-state and outputs, evaluated only at frame close
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        lat_nxt       = lat;
        key_code_nxt  = key_code;
        key_valid_nxt = 1'b0;
        key_held_nxt  = key_held;
        accept_c      = 1'b0;
        if (frame_close) begin
            case (state)
                IDLE: begin
                    if (cand_valid) begin
                        lat_nxt = cand_code;
                        cnt_nxt = CNT_ONE;
                        if (CNT_ONE >= CNT_MAX) accept_c = 1'b1;
                        else                    state_nxt = DEBOUNCE;
                    end
                end
                DEBOUNCE: begin
                    if (cand_valid && (cand_code == lat)) begin
                        cnt_nxt = cnt_inc;
                        if (cnt_inc >= CNT_MAX) accept_c = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end
                end
                PRESSED: begin
                    if (!cand_valid) begin
                        if (CNT_ONE >= CNT_MAX) begin
                            state_nxt    = IDLE;
                            cnt_nxt      = '0;
                            key_held_nxt = 1'b0;
                        end else begin
                            state_nxt = RELEASE;
                            cnt_nxt   = CNT_ONE;
                        end
                    end
                end
                RELEASE: begin
                    if (!cand_valid) begin
                        cnt_nxt = cnt_inc;
                        if (cnt_inc >= CNT_MAX) begin
                            state_nxt    = IDLE;
                            cnt_nxt      = '0;
                            key_held_nxt = 1'b0;
                        end
                    end else begin
                        state_nxt = PRESSED;
                        cnt_nxt   = '0;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
            if (accept_c) begin
                state_nxt     = PRESSED;
                cnt_nxt       = '0;
                key_code_nxt  = lat_nxt;
                key_valid_nxt = 1'b1;
                key_held_nxt  = 1'b1;
            end
        end
    end

    // FSM state and registered key outputs
    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            lat       <= 4'h0;
            key_code  <= 4'h0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            lat       <= lat_nxt;
            key_code  <= key_code_nxt;
            key_valid <= key_valid_nxt;
            key_held  <= key_held_nxt;
        end
    end

`ifdef KEYPAD_BCD_ENTRY_EN
    // BCD entry: digit keys shift in from the right, C clears, other letters ignored
    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            ones      <= 4'h0;
            tens      <= 4'h0;
            hundreds  <= 4'h0;
            thousands <= 4'h0;
        end else if (accept_c) begin
            if (key_code_nxt <= 4'd9) begin
                thousands <= hundreds;
                hundreds  <= tens;
                tens      <= ones;
                ones      <= key_code_nxt;
            end else if (key_code_nxt == 4'hC) begin
                ones      <= 4'h0;
                tens      <= 4'h0;
                hundreds  <= 4'h0;
                thousands <= 4'h0;
            end
        end
    end
`else
    assign ones      = 4'h0;
    assign tens      = 4'h0;
    assign hundreds  = 4'h0;
    assign thousands = 4'h0;
`endif

endmodule

// File: tb/tb_keypad_scan.sv
// Self-checking bench for keypad_scan: a keypad matrix model drives the rows from the
// DUT column drive; a frame-level reference model predicts accepted keys and digits.
module tb_keypad_scan;

    localparam int unsigned ST = 4;
    localparam int unsigned DS = 2;

    logic       clk_100MHz = 1'b0;
    logic       reset_n;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;
    logic [3:0] ones, tens, hundreds, thousands;

    logic [15:0] mask;

    int checks   = 0;
    int failures = 0;
    int seen_pulses = 0;

    // reference model state
    bit         m_held;
    int         m_streak;
    int         m_rel;
    logic [3:0] m_lat;
    logic [3:0] m_code;
    bit         m_pulse;
    int         m_pulses;
    int         m_d[4];

    keypad_scan #(.SCAN_TICKS(ST), .DEBOUNCE_SCANS(DS)) dut (
        .clk_100MHz(clk_100MHz),
        .reset_n   (reset_n),
        .row       (row),
        .col       (col),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held),
        .ones      (ones),
        .tens      (tens),
        .hundreds  (hundreds),
        .thousands (thousands)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    // Keypad matrix: a pressed key shorts its row to any column driven low
    always_comb begin
        row = 4'hF;
        for (int c = 0; c < 4; c++)
            if (!col[c])
                for (int r = 0; r < 4; r++)
                    if (mask[r*4+c]) row[r] = 1'b0;
    end

    always @(posedge clk_100MHz)
        if (key_valid === 1'b1) seen_pulses++;

    function automatic logic [15:0] k(input int code);
        logic [15:0] one;
        one = 16'd1;
        return one << code;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_held = 0; m_streak = 0; m_rel = 0; m_lat = 4'h0; m_code = 4'h0; m_pulse = 0;
        for (int i = 0; i < 4; i++) m_d[i] = 0;
    endtask

    // One full scan frame of the reference behaviour
    task automatic model_frame(input logic [15:0] mk);
        bit cv;
        logic [3:0] cc;
        cv = 0; cc = 4'h0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (!cv && mk[r*4+c]) begin cv = 1; cc = 4'(r*4 + c); end
        m_pulse = 0;
        if (!m_held) begin
            if (!cv)                m_streak = 0;
            else if (m_streak == 0) begin m_lat = cc; m_streak = 1; end
            else if (cc == m_lat)   m_streak++;
            else                    m_streak = 0;
            if (m_streak >= DS) begin
                m_held = 1; m_rel = 0; m_streak = 0; m_pulse = 1;
                m_code = m_lat; m_pulses++;
`ifdef KEYPAD_BCD_ENTRY_EN
                if (m_code <= 4'd9) begin
                    m_d[3] = m_d[2]; m_d[2] = m_d[1]; m_d[1] = m_d[0]; m_d[0] = int'(m_code);
                end else if (m_code == 4'hC) begin
                    for (int i = 0; i < 4; i++) m_d[i] = 0;
                end
`endif
            end
        end else begin
            if (cv) m_rel = 0;
            else begin
                m_rel++;
                if (m_rel >= DS) begin m_held = 0; m_rel = 0; end
            end
        end
    endtask

    // Apply a key mask for one 16-cycle frame, checking every cycle
    task automatic run_frame(input logic [15:0] mk);
        bit old_held;
        logic [3:0] old_code, exp_col;
        mask = mk;
        old_held = m_held;
        old_code = m_code;
        model_frame(mk);
        for (int j = 1; j <= 4*int'(ST); j++) begin
            @(posedge clk_100MHz);
            #1;
            exp_col = 4'hF ^ (4'd1 << ((j / int'(ST)) % 4));
            chk("col", 16'(col), 16'(exp_col));
            if (j == 4*int'(ST)) begin
                chk("key_valid", 16'(key_valid), 16'(m_pulse));
                chk("key_held", 16'(key_held), 16'(m_held));
                chk("key_code", 16'(key_code), 16'(m_code));
                chk("ones", 16'(ones), 16'(m_d[0]));
                chk("tens", 16'(tens), 16'(m_d[1]));
                chk("hundreds", 16'(hundreds), 16'(m_d[2]));
                chk("thousands", 16'(thousands), 16'(m_d[3]));
            end else begin
                chk("key_valid_idle", 16'(key_valid), 16'd0);
                chk("key_held_mid", 16'(key_held), 16'(old_held));
                chk("key_code_mid", 16'(key_code), 16'(old_code));
            end
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_col"}, 16'(col), 16'h000E);
        chk({tag, "_key_code"}, 16'(key_code), 16'd0);
        chk({tag, "_key_valid"}, 16'(key_valid), 16'd0);
        chk({tag, "_key_held"}, 16'(key_held), 16'd0);
        chk({tag, "_digits"}, {thousands, hundreds, tens, ones}, 16'd0);
    endtask

    initial begin
        logic [15:0] cur;
        int pulses_before;
        int mode;
        int seq[6];
        mask = 16'h0;
        m_pulses = 0;
        model_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk_100MHz);
        chk_reset_vals("reset");
        reset_n = 1'b1;

        // idle scanning, no keys
        repeat (3) run_frame(16'h0);

        // key 5 held three frames, then released
        repeat (3) run_frame(k(5));
        chk("key5_code", 16'(key_code), 16'h5);
        chk("key5_held", 16'(key_held), 16'd1);
        run_frame(16'h0);
        chk("key5_held_1empty", 16'(key_held), 16'd1);
        run_frame(16'h0);
        chk("key5_released", 16'(key_held), 16'd0);

        // bounce: one frame only
        pulses_before = m_pulses;
        run_frame(k(7));
        repeat (2) run_frame(16'h0);
        chk("bounce_no_pulse", 16'(m_pulses - pulses_before), 16'd0);
        chk("bounce_code_kept", 16'(key_code), 16'h5);

        // two keys at once: lowest column wins
        repeat (3) run_frame(k(1) | k(6));
        chk("multi_code", 16'(key_code), 16'h1);
        repeat (3) run_frame(16'h0);

        // digit entry sequence 1,2,3,4,5 then C
        seq = '{1, 2, 3, 4, 5, 12};
        for (int i = 0; i < 5; i++) begin
            repeat (2) run_frame(k(seq[i]));
            repeat (2) run_frame(16'h0);
        end
`ifdef KEYPAD_BCD_ENTRY_EN
        chk("bcd_entry", {thousands, hundreds, tens, ones}, 16'h2345);
`else
        chk("bcd_disabled", {thousands, hundreds, tens, ones}, 16'h0000);
`endif
        repeat (2) run_frame(k(seq[5]));
        repeat (2) run_frame(16'h0);
        chk("bcd_clear", {thousands, hundreds, tens, ones}, 16'h0000);

        // randomized key activity
        cur = 16'h0;
        for (int f = 0; f < 60; f++) begin
            mode = int'($urandom_range(0, 9));
            if (mode == 5 || mode == 6) cur = 16'h0;
            else if (mode == 7 || mode == 8) cur = k(int'($urandom_range(0, 15)));
            else if (mode == 9) cur = k(int'($urandom_range(0, 15))) | k(int'($urandom_range(0, 15)));
            run_frame(cur);
        end
        repeat (3) run_frame(16'h0);

        // reset asserted mid-debounce with key held
        run_frame(k(10));
        mask = k(10);
        repeat (6) @(posedge clk_100MHz);
        #2;
        reset_n = 1'b0;
        #1;
        chk_reset_vals("midreset");
        model_reset();
        repeat (2) @(negedge clk_100MHz);
        reset_n = 1'b1;
        pulses_before = m_pulses;
        run_frame(k(10));
        chk("post_reset_no_early", 16'(key_valid), 16'd0);
        run_frame(k(10));
        chk("post_reset_pulse", 16'(m_pulses - pulses_before), 16'd1);
        chk("post_reset_code", 16'(key_code), 16'hA);
        repeat (3) run_frame(16'h0);

        chk("pulse_total", 16'(seen_pulses), 16'(m_pulses));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
